// File: rtl/pwm_bank_pkg.sv
// Shared types and address/limit helpers for the pwm_bank PWM generator.
package pwm_bank_pkg;

    typedef enum logic [0:0] {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int unsigned addr_presc(input int unsigned num_ch);
        return num_ch;
    endfunction

    function automatic int unsigned addr_en(input int unsigned num_ch);
        return num_ch + 32'd1;
    endfunction

    function automatic int unsigned addr_mode(input int unsigned num_ch);
        return num_ch + 32'd2;
    endfunction

    // Top of the count range; leaves 2^cnt_w-1 as an always-high duty code.
    function automatic int unsigned cnt_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd2;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable divider: tick fires once every div+1 clocks; clr restarts the count.
module pwm_prescaler #(
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] div,
    input  logic               clr,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt;

    assign tick = (presc_cnt == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (clr || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM with double-buffered duty registers and a shared prescaler.
// Define PWM_CENTER_ALIGN_EN to enable the centre-aligned (triangle) counting mode.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PRESC_W = 8,
    parameter int unsigned ADDR_W  = $clog2(NUM_CH + 3)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [ADDR_W-1:0] A_PRESC = ADDR_W'(addr_presc(NUM_CH));
    localparam logic [ADDR_W-1:0] A_EN    = ADDR_W'(addr_en(NUM_CH));

    logic [PRESC_W-1:0] presc_div;
    logic [NUM_CH-1:0]  en_mask;
    logic [CNT_W-1:0]   duty_pend [NUM_CH];
    logic [CNT_W-1:0]   duty_act  [NUM_CH];
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               dir;
    logic               dir_nxt;
    logic               boundary;
    logic               tick;
    logic               wr_presc;
    logic               wr_mask;
    logic [NUM_CH-1:0]  wr_duty;
    logic [NUM_CH-1:0]  en_eff;
    logic [NUM_CH-1:0]  pwm_nxt;
    pwm_mode_e          mode_act;

    assign wr_presc = wr_en && (wr_addr == A_PRESC);
    assign wr_mask  = wr_en && (wr_addr == A_EN);

    always_comb begin
        wr_duty = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_duty[i] = wr_en && (wr_addr == ADDR_W'(i));
        end
    end

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .div  (presc_div),
        .clr  (wr_presc),
        .tick (tick)
    );

`ifdef PWM_CENTER_ALIGN_EN
    localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(addr_mode(NUM_CH));

    logic      wr_mode;
    pwm_mode_e mode_pend;

    assign wr_mode = wr_en && (wr_addr == A_MODE);

    // Mode is latched only at a boundary so a period never changes shape mid-way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_pend <= PWM_EDGE;
            mode_act  <= PWM_EDGE;
        end else begin
            if (wr_mode) begin
                mode_pend <= pwm_mode_e'(wr_data[0]);
            end
            if (boundary) begin
                mode_act <= wr_mode ? pwm_mode_e'(wr_data[0]) : mode_pend;
            end
        end
    end
`else
    assign mode_act = PWM_EDGE;
`endif

    // Period counter next state and boundary detection.
    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (tick) begin
            if (mode_act == PWM_EDGE) begin
                dir_nxt = DIR_UP;
                if (cnt == CNT_MAX) begin
                    cnt_nxt  = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end else if (dir == DIR_UP) begin
                if (cnt == CNT_MAX) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    dir_nxt = DIR_DOWN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end else begin
                if (cnt == CNT_W'(1)) begin
                    cnt_nxt  = '0;
                    dir_nxt  = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
        end
    end

    // Enable writes bypass the register so a channel reacts on the capturing edge.
    always_comb begin
        en_eff  = wr_mask ? wr_data[NUM_CH-1:0] : en_mask;
        pwm_nxt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pwm_nxt[i] = en_eff[i] && (cnt < duty_act[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_div   <= '0;
            en_mask     <= '0;
            cnt         <= '0;
            dir         <= DIR_UP;
            period_tick <= 1'b0;
            pwm_out     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                duty_pend[i] <= '0;
                duty_act[i]  <= '0;
            end
        end else begin
            if (wr_presc) begin
                presc_div <= wr_data[PRESC_W-1:0];
            end
            if (wr_mask) begin
                en_mask <= wr_data[NUM_CH-1:0];
            end
            cnt         <= cnt_nxt;
            dir         <= dir_nxt;
            period_tick <= boundary;
            pwm_out     <= pwm_nxt;
            // A duty write on the boundary clock is forwarded into the new period.
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_duty[i]) begin
                    duty_pend[i] <= wr_data;
                end
                if (boundary) begin
                    duty_act[i] <= wr_duty[i] ? wr_data : duty_pend[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank against a period-position reference model.
module tb_pwm_bank;

    localparam int unsigned NCH  = 8;
    localparam int unsigned CW   = 8;
    localparam int unsigned AW   = 4;
    localparam int unsigned MAXV = 254;
`ifdef PWM_CENTER_ALIGN_EN
    localparam bit CENTER = 1'b1;
`else
    localparam bit CENTER = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [CW-1:0]  wr_data;
    logic [NCH-1:0] pwm_out;
    logic           period_tick;

    always #5 clk = ~clk;

    pwm_bank #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .PRESC_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position within the current period, in prescaler ticks.
    int unsigned m_div, m_elapsed, m_pos;
    logic [7:0]  m_pend [NCH];
    logic [7:0]  m_act  [NCH];
    logic [7:0]  m_en;
    bit          m_mode, m_mode_pend;
    logic [7:0]  e_pwm;
    bit          e_tick;

    int since, ones0, last_spacing, last_ones0;

    function automatic int unsigned period_len();
        return m_mode ? 2 * MAXV : MAXV + 1;
    endfunction

    task automatic model_reset();
        m_div = 0; m_elapsed = 0; m_pos = 0; m_en = '0;
        m_mode = 1'b0; m_mode_pend = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = '0;
            m_act[i]  = '0;
        end
        e_pwm = '0; e_tick = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        int unsigned c;
        bit          tk, bnd;
        logic [7:0]  en_now;
        c = (m_pos <= MAXV) ? m_pos : 2 * MAXV - m_pos;
        en_now = (we && a == NCH + 1) ? d : m_en;
        for (int i = 0; i < NCH; i++) e_pwm[i] = en_now[i] && (c < m_act[i]);
        tk  = (m_elapsed % (m_div + 1)) == m_div;
        bnd = tk && (m_pos == period_len() - 1);
        e_tick = bnd;
        if (bnd) begin
            for (int i = 0; i < NCH; i++) m_act[i] = (we && a == i) ? d : m_pend[i];
            m_mode = (CENTER && we && a == NCH + 2) ? d[0] : m_mode_pend;
            m_pos  = 0;
        end else if (tk) begin
            m_pos++;
        end
        m_elapsed = (we && a == NCH) ? 0 : m_elapsed + 1;
        if (we) begin
            if (a < NCH)                    m_pend[a]   = d;
            else if (a == NCH)              m_div       = d;
            else if (a == NCH + 1)          m_en        = d;
            else if (a == NCH + 2 && CENTER) m_mode_pend = d[0];
        end
    endtask

    // One clock: drive, advance model, sample #1 after the edge, compare.
    task automatic cyc(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        wr_en = we; wr_addr = a; wr_data = d;
        model_step(we, a, d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("pwm_out", 32'(pwm_out), 32'(e_pwm));
        check("period_tick", 32'(period_tick), 32'(e_tick));
        if (period_tick) begin
            last_spacing = since;
            last_ones0   = ones0;
            since        = 1;
            ones0        = int'(pwm_out[0]);
        end else begin
            since++;
            ones0 += int'(pwm_out[0]);
        end
    endtask

    task automatic wait_tick(input int budget, input string tag, output int n);
        n = 0;
        do begin
            cyc(1'b0, '0, '0);
            n++;
        end while (!period_tick && n < budget);
        if (!period_tick) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, ones1, ones2;
        logic [AW-1:0] ra;
        logic [7:0]    rd;
        since = 0; ones0 = 0; last_spacing = 0; last_ones0 = 0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_tick", 32'(period_tick), 32'd0);
        rst = 1'b0;

        // Random writes, then an asynchronous reset mid-operation.
        for (int i = 0; i < 40; i++) cyc(1'b1, AW'($urandom_range(0, 11)), 8'($urandom));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 32'd0);
        check("async_rst_tick", 32'(period_tick), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("rst_hold_pwm", 32'(pwm_out), 32'd0);
        rst = 1'b0;
        model_reset();
        wait_tick(2000, "first_tick_timeout", n);
        check("first_tick_delay", 32'(n), 32'd255);

        // Basic duty.
        cyc(1'b1, 4'd0, 8'd64);
        cyc(1'b1, 4'd9, 8'h01);
        cyc(1'b1, 4'd8, 8'd0);
        wait_tick(600, "basic_timeout", n);
        wait_tick(600, "basic_timeout", n);
        check("basic_high", 32'(last_ones0), 32'd64);
        check("basic_period", 32'(last_spacing), 32'd255);

        // Extremes and immediate enable.
        cyc(1'b1, 4'd1, 8'd0);
        cyc(1'b1, 4'd2, 8'd255);
        cyc(1'b1, 4'd9, 8'h06);
        wait_tick(600, "extreme_timeout", n);
        cyc(1'b0, '0, '0);
        ones1 = 0; ones2 = 0;
        for (int i = 0; i < 3 * 255; i++) begin
            cyc(1'b0, '0, '0);
            ones1 += int'(pwm_out[1]);
            ones2 += int'(pwm_out[2]);
        end
        check("duty_zero_ch1", 32'(ones1), 32'd0);
        check("duty_full_ch2", 32'(ones2), 32'd765);
        cyc(1'b1, 4'd9, 8'h02);
        check("en_clear_ch2", 32'(pwm_out[2]), 32'd0);

        // Double buffering and boundary-clock forwarding.
        cyc(1'b1, 4'd9, 8'h07);
        cyc(1'b1, 4'd0, 8'd64);
        wait_tick(600, "dbuf_timeout", n);
        wait_tick(600, "dbuf_timeout", n);
        n = 0;
        while (m_pos != 10 && n < 600) begin cyc(1'b0, '0, '0); n++; end
        cyc(1'b1, 4'd0, 8'd128);
        wait_tick(600, "dbuf_timeout", n);
        check("dbuf_old_period", 32'(last_ones0), 32'd64);
        wait_tick(600, "dbuf_timeout", n);
        check("dbuf_new_period", 32'(last_ones0), 32'd128);
        n = 0;
        while (m_pos != MAXV && n < 600) begin cyc(1'b0, '0, '0); n++; end
        cyc(1'b1, 4'd0, 8'd200);
        check("bnd_write_tick", 32'(period_tick), 32'd1);
        wait_tick(600, "bnd_timeout", n);
        check("bnd_write_high", 32'(last_ones0), 32'd200);

        // Prescaler.
        cyc(1'b1, 4'd0, 8'd64);
        cyc(1'b1, 4'd8, 8'd3);
        wait_tick(3000, "presc_timeout", n);
        wait_tick(3000, "presc_timeout", n);
        check("presc_period", 32'(last_spacing), 32'd1020);
        check("presc_high", 32'(last_ones0), 32'd256);
        repeat (6) cyc(1'b0, '0, '0);
        cyc(1'b1, 4'd8, 8'd3);
        repeat (9) cyc(1'b0, '0, '0);
        cyc(1'b1, 4'd8, 8'd0);
        wait_tick(3000, "presc_timeout", n);

        // Centre-aligned mode (ignored when the feature is not built).
        cyc(1'b1, 4'd10, 8'd1);
        wait_tick(1200, "mode_timeout", n);
        wait_tick(1200, "mode_timeout", n);
        check("mode_period", 32'(last_spacing), CENTER ? 32'd508 : 32'd255);
        check("mode_high", 32'(last_ones0), CENTER ? 32'd127 : 32'd64);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                ra = AW'($urandom_range(0, 15));
                rd = (ra == 4'd8) ? 8'($urandom_range(0, 2)) : 8'($urandom);
                cyc(1'b1, ra, rd);
            end else begin
                cyc(1'b0, '0, '0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
